tail_light_seq: RTL
===================

Name: tail_light_seq

Overview:
- Parametrised successor to the 6-lamp left/right turn-signal FSM.
- Drives 2×LAMPS_PER_SIDE tail lamps with a sequential "walking" turn indication per side and a hazard mode that flashes all lamps.
- Adds a step prescaler so the animation rate is set independently of clk.
- Sits between the driver-switch inputs and the lamp drivers.

Parameters:
- LAMPS_PER_SIDE, 3, lamps per side (N); legal range 1..16.
- STEP_DIV, 1, clk cycles per animation step; legal range ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- left  input  1  left turn request, level.
- right  input  1  right turn request, level.
- hazard  input  1  hazard request, level.
- y  output  2*N  lamp drives. y[2N-1:N] is the left side, y[N] innermost, y[2N-1] outermost. y[N-1:0] is the right side, y[N-1] innermost, y[0] outermost.
- active  output  1  high whenever state ≠ IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - At the next rising edge with reset=1: state=IDLE, prescaler=0, y=0, active=0.
  - Reset overrides tick and all inputs, including mid-sequence.
- Prescaler:
  - Counter width max(1,$clog2(STEP_DIV)).
  - Counts 0..STEP_DIV-1, then wraps to 0.
  - tick=1 when count==STEP_DIV-1. With STEP_DIV=1, tick is constantly 1.
  - The counter runs freely in all states. It is not restarted by input changes.
- State transitions happen only on a rising edge where tick=1. Otherwise the state holds.
- Inputs are sampled at that edge. No input synchronisation is done in this block.
- States: IDLE, L1..LN, R1..RN, HAZ (2N+2 states). Encoding is implementer's choice.
- IDLE transitions, in priority order:
  - hazard=1, or left=1 and right=1 -> HAZ.
  - left=1 -> L1.
  - right=1 -> R1.
  - otherwise stay in IDLE.
- Lk (k<N): hazard=1 -> IDLE (abort); else -> L(k+1).
- LN -> IDLE unconditionally.
- Rk and RN: mirror of Lk and LN.
- left/right changes during a sequence are ignored. The sequence always completes unless hazard aborts it.
- HAZ -> IDLE unconditionally. If the hazard request persists, IDLE re-enters HAZ on the next tick, giving a 50% flash with period 2 steps.
- Release during HAZ: the state still exits to IDLE on the next tick. There is no stuck-on condition.
- Outputs are Moore, decoded from the registered state, so they change in the cycle after the transition edge:
  - IDLE: y=0.
  - Lk: left innermost k lamps on, i.e. y[N+k-1:N]=all 1. Everything else is 0.
  - Rk: right innermost k lamps on, i.e. y[N-1:N-k]=all 1. Everything else is 0.
  - HAZ: y = all 1.
  - active = (state≠IDLE).
- Latency: a request present at a tick edge while in IDLE appears on y immediately after that edge.
- Full turn cycle: N lit steps plus 1 dark step = (N+1)*STEP_DIV clk cycles.
- Boundary rules:
  - left and right together are treated as hazard.
  - hazard arriving on the final step (LN/RN) produces no extra dark step; the next state is IDLE either way.
  - N=1: L1 is both first and last step.

Test Plan (N=3 unless noted; y shown as y[5:0]):
- Reset then left: reset 2 cycles, then left=1, right=0, hazard=0, STEP_DIV=1.
  - Required y on successive cycles: 000000, 001000, 011000, 111000, 000000, 001000, …
  - active=0 only on the dark step.
- Right with prescaler: right=1 held, STEP_DIV=4.
  - Each value is held 4 cycles: 000100, 000110, 000111, 000000.
  - Full period is 16 cycles.
- Hazard flash: hazard=1 (and separately left=right=1), STEP_DIV=1.
  - y alternates 111111, 000000 every cycle.
  - Releasing during 111111 gives 000000 next, then stays 000000.
- Abort and ignore:
  - left at L2 (011000), pulse right=1 -> sequence continues to 111000, 000000 (right ignored).
  - hazard=1 at L2 -> next y=000000, then 111111.
- Reset mid-operation: assert reset while y=011000 with STEP_DIV=4 mid-count.
  - Next edge gives y=000000, active=0, prescaler=0.
  - After release, the first transition occurs exactly 4 cycles later.
- Parameter sweep: N=1 and N=5.
  - N=1 left gives y[1:0]=10, 00 alternating.
  - N=5 right walks 0000010000 through 0000011111, then 0000000000.

Source files
------------

// File: rtl/tail_light_seq.sv
// Sequential "walking" turn-signal and hazard controller for 2*LAMPS_PER_SIDE tail lamps,
// with a free-running step prescaler that sets the animation rate.
module tail_light_seq #(
    parameter int unsigned LAMPS_PER_SIDE = 3,
    parameter int unsigned STEP_DIV       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          left,
    input  logic                          right,
    input  logic                          hazard,
    output logic [2*LAMPS_PER_SIDE-1:0]   y,
    output logic                          active
);

    localparam int unsigned N  = LAMPS_PER_SIDE;
    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned SW = $clog2(N + 1);

    // Lk/Rk are represented as a direction mode plus the current step index k.
    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_LEFT,
        MODE_RIGHT,
        MODE_HAZ
    } mode_e;

    mode_e           mode;
    mode_e           mode_next;
    logic [SW-1:0]   step;
    logic [SW-1:0]   step_next;
    logic [CW-1:0]   count;
    logic            tick;
    logic [2*N-1:0]  y_next;
    logic            active_next;

    assign tick = (count == CW'(STEP_DIV - 1));

    // State register; outputs are registered alongside from the decoded next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            mode   <= MODE_IDLE;
            step   <= '0;
            y      <= '0;
            active <= 1'b0;
        end else begin
            count  <= tick ? '0 : count + CW'(1);
            mode   <= mode_next;
            step   <= step_next;
            y      <= y_next;
            active <= active_next;
        end
    end

    // Next-state logic: transitions only on a prescaler tick.
    always_comb begin
        mode_next = mode;
        step_next = step;
        if (tick) begin
            case (mode)
                MODE_IDLE: begin
                    if (hazard || (left && right)) begin
                        mode_next = MODE_HAZ;
                        step_next = '0;
                    end else if (left) begin
                        mode_next = MODE_LEFT;
                        step_next = SW'(1);
                    end else if (right) begin
                        mode_next = MODE_RIGHT;
                        step_next = SW'(1);
                    end
                end
                MODE_LEFT, MODE_RIGHT: begin
                    if ((step == SW'(N)) || hazard) begin
                        mode_next = MODE_IDLE;
                        step_next = '0;
                    end else begin
                        step_next = step + SW'(1);
                    end
                end
                default: begin
                    mode_next = MODE_IDLE;
                    step_next = '0;
                end
            endcase
        end
    end

    // Lamp decode: lamp i counted from the inner edge lights when i < k.
    always_comb begin
        y_next      = '0;
        active_next = (mode_next != MODE_IDLE);
        for (int i = 0; i < int'(N); i++) begin
            case (mode_next)
                MODE_LEFT:  y_next[N + i]     = (32'(i) < 32'(step_next));
                MODE_RIGHT: y_next[N - 1 - i] = (32'(i) < 32'(step_next));
                MODE_HAZ: begin
                    y_next[N + i]     = 1'b1;
                    y_next[N - 1 - i] = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
